// File: rtl/bus_arb8_rr_pkg.sv
// Shared constants, FSM state type and the one-hot helper used by the
// 8-way round-robin write-back bus arbiter.
package arb_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/bus_arb8_rr_pick8.sv
// Rotating priority encoder: first set bit of mask at or above ptr,
// wrapping from bit 7 back to bit 0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SEL_W-1:0]  pos;
  logic              found;

  always_comb begin
    dbl   = {mask, mask} >> ptr;
    rot   = dbl[NREQ-1:0];
    any   = |mask;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        pos   = i[SEL_W-1:0];
        found = 1'b1;
      end
    end
    // Offset back into absolute index space; 3-bit add wraps naturally.
    idx = ptr + pos;
  end

endmodule

// File: rtl/bus_arb8_rr.sv
// Round-robin arbiter for the 16-bit 8:1 write-back mux with tenure-based
// preemption. Optional LOCK input (suppresses preemption) under ARB_LOCK_EN.
module bus_arb8_rr
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
`ifdef ARB_LOCK_EN
  input  logic             LOCK,
`endif
  input  logic [NREQ-1:0]  REQ,
  output logic [NREQ-1:0]  GNT,
  output logic [SEL_W-1:0] SEL,
  output logic             VALID,
  output logic             PREEMPT
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Handshake: REQ[i] is a level request held until GNT[i] is seen; the
  // grant is registered, one-hot, and valid exactly while VALID is high.

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             valid_q;
  logic             pre_q, pre_d;

  logic [NREQ-1:0]  cand;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             lock_w;
  logic             take;

`ifdef ARB_LOCK_EN
  assign lock_w = LOCK;
`else
  assign lock_w = 1'b0;
`endif

  assign owner_req = REQ[sel_q];
  // While owning, the current owner is excluded from the candidates.
  assign cand = (state_q == OWN) ? (REQ & ~gnt_q) : REQ;

  rr_pick8 u_pick (
    .mask (cand),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    pre_d   = 1'b0;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) take = 1'b1;
      end
      OWN: begin
        if (!owner_req) begin
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (!lock_w && cnt_q == HOLD_LAST && pick_any) begin
          take  = 1'b1;
          pre_d = 1'b1;
        end else if (!lock_w && cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (take) begin
      state_d = OWN;
      gnt_d   = onehot(pick_idx);
      sel_d   = pick_idx;
      cnt_d   = '0;
      ptr_d   = pick_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      valid_q <= (state_d == OWN);
      pre_q   <= pre_d;
    end
  end

  assign GNT     = gnt_q;
  assign SEL     = sel_q;
  assign VALID   = valid_q;
  assign PREEMPT = pre_q;

endmodule

// File: tb/tb_bus_arb8_rr.sv
// Self-checking bench for bus_arb8_rr: directed scenarios plus randomized
// request traffic against a behavioural round-robin model.
module tb_bus_arb8_rr;

  localparam int MAX_HOLD = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] REQ = '0;
  logic       lk_v = 1'b0;
  logic [7:0] GNT;
  logic [2:0] SEL;
  logic       VALID;
  logic       PREEMPT;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: owner index (-1 when idle), tenure, pointer.
  int   m_owner = -1;
  int   m_sel = 0;
  int   m_cnt = 0;
  int   m_ptr = 0;
  logic m_pre = 1'b0;

  always #5 CLK = ~CLK;

  bus_arb8_rr #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
`ifdef ARB_LOCK_EN
    .LOCK    (lk_v),
`endif
    .REQ     (REQ),
    .GNT     (GNT),
    .SEL     (SEL),
    .VALID   (VALID),
    .PREEMPT (PREEMPT)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] m, input int p);
    for (int k = 0; k < 8; k++)
      if (m[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] exp_gnt();
    logic [7:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_cnt = 0; m_ptr = 0; m_pre = 1'b0;
  endtask

  task automatic model_grant(input int c);
    m_owner = c; m_sel = c; m_cnt = 0; m_ptr = (c + 1) % 8;
  endtask

  task automatic model_clock(input logic [7:0] req, input logic lk);
    logic [7:0] others;
    int c;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      c = pick(req, m_ptr);
      if (c >= 0) model_grant(c);
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        c = pick(others, m_ptr);
        if (c >= 0) model_grant(c);
        else m_owner = -1;
      end else if (!lk && m_cnt == MAX_HOLD - 1 && others != 0) begin
        model_grant(pick(others, m_ptr));
        m_pre = 1'b1;
      end else if (!lk && m_cnt < MAX_HOLD - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [7:0] req);
    REQ = req;
    @(posedge CLK);
    model_clock(req, lk_v);
    #1;
    check("gnt", GNT, exp_gnt());
    check("sel", {5'd0, SEL}, 8'(m_sel));
    check("valid", {7'd0, VALID}, {7'd0, m_owner >= 0});
    check("preempt", {7'd0, PREEMPT}, {7'd0, m_pre});
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ   = '0;
    lk_v  = 1'b0;
    model_reset();
    @(negedge CLK);
    check("rst_gnt", GNT, 8'h00);
    check("rst_sel", {5'd0, SEL}, 8'h00);
    check("rst_valid", {7'd0, VALID}, 8'h00);
    check("rst_preempt", {7'd0, PREEMPT}, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] e;
    int npre;

    // Single requester grant and release.
    do_reset();
    step(8'h01);
    check("t1_gnt", GNT, 8'h01);
    step(8'h00);
    check("t1_idle", GNT, 8'h00);

    // Full rotation, each owner releasing after one cycle.
    do_reset();
    step(8'hFF);
    check("t2_gnt0", GNT, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      step(~exp_gnt());
      e = '0;
      e[k % 8] = 1'b1;
      check("t2_rot", GNT, e);
      check("t2_sel", {5'd0, SEL}, 8'(k % 8));
    end

    // Forced rotation after MAX_HOLD cycles of tenure.
    do_reset();
    npre = 0;
    for (int k = 1; k <= 6; k++) begin
      step(8'h28);
      if (PREEMPT) npre++;
      if (k == 4) check("t3_hold", GNT, 8'h08);
      if (k == 5) begin
        check("t3_pre_gnt", GNT, 8'h20);
        check("t3_pre_sel", {5'd0, SEL}, 8'h05);
        check("t3_pre", {7'd0, PREEMPT}, 8'h01);
      end
    end
    check("t3_npre", 8'(npre), 8'h01);

    // Lone requester keeps the grant indefinitely.
    do_reset();
    npre = 0;
    for (int k = 0; k < 20; k++) begin
      step(8'h04);
      check("t4_gnt", GNT, 8'h04);
      if (PREEMPT) npre++;
    end
    check("t4_npre", 8'(npre), 8'h00);

    // Releasing owner re-raising gets lowest priority.
    do_reset();
    step(8'h40);
    check("t5_own6", GNT, 8'h40);
    step(8'h02);
    check("t5_next1", GNT, 8'h02);
    step(8'h40);
    check("t5_then6", GNT, 8'h40);

    // Asynchronous reset mid-grant.
    do_reset();
    step(8'h10);
    check("t6_own4", GNT, 8'h10);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_async_gnt", GNT, 8'h00);
    check("t6_async_sel", {5'd0, SEL}, 8'h00);
    check("t6_async_valid", {7'd0, VALID}, 8'h00);
    model_reset();
    REQ = 8'h11;
    @(negedge CLK);
    RST_N = 1'b1;
    step(8'h11);
    check("t6_first", GNT, 8'h01);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r &= 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
      if ($urandom_range(0, 15) == 0) r = 8'h00;
`ifdef ARB_LOCK_EN
      lk_v = ($urandom_range(0, 5) == 0);
`endif
      step(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
